// File: rtl/stack_pkg.sv
// Shared definitions for the multi-port stack and its upstream push packer.
// Widths are derived from the lane count and the staging depth.
package stack_pkg;

    localparam int DATA   = 64;              // entry width
    localparam int PUSH   = 2;               // lanes in and out
    localparam int BUF    = 8;               // staging depth, power of 2, >= 2*PUSH
    localparam int PTR_W  = $clog2(BUF);     // head/tail width, wraps modulo BUF
    localparam int CNT_W  = PTR_W + 1;       // staged count 0..BUF
    localparam int LANE_W = $clog2(PUSH + 1); // per-cycle lane count 0..PUSH

    typedef logic [DATA-1:0]  stack_ent_t;
    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic {PP_RUN, PP_FLUSH} pp_state_e;

    // Population count of a lane vector.
    function automatic logic [LANE_W-1:0] cnt_bits(input logic [PUSH-1:0] v);
        logic [LANE_W-1:0] c;
        c = '0;
        for (int i = 0; i < PUSH; i++) begin
            c = c + LANE_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/stack_push_pack_lane_pack.sv
// lane_pack: compacts sparse active lanes into lanes 0..n-1, keeping lane order.
// Each active lane lands at the number of active lanes below it.
module lane_pack
    import stack_pkg::*;
(
    input  logic [PUSH-1:0]      act,
    input  logic [PUSH*DATA-1:0] lane_d,
    output logic [LANE_W-1:0]    acc_n,
    output logic [PUSH*DATA-1:0] pk_d
);

    logic [PUSH-1:0]   below;
    logic [LANE_W-1:0] off;

    // Exclusive prefix count gives each active lane its packed destination.
    always_comb begin
        pk_d  = '0;
        below = '0;
        off   = '0;
        acc_n = cnt_bits(act);
        for (int i = 0; i < PUSH; i++) begin
            below = '0;
            for (int j = 0; j < i; j++) begin
                below[j] = 1'b1;
            end
            off = cnt_bits(act & below);
            if (act[i]) begin
                pk_d[int'(off)*DATA +: DATA] = lane_d[i*DATA +: DATA];
            end
        end
    end

endmodule

// File: rtl/stack_push_pack.sv
// stack_push_pack: packs sparse producer requests into a staging FIFO and
// issues up to PUSH packed entries per cycle to the stack, honouring busy.
// Optional macro STACK_PUSH_PACK_STAT_EN adds the stall_cnt output.
// Handshake: a request is taken on a clock edge only when in_rdy is high in
// that cycle; producers hold in_/in_d while in_rdy is low. push_ is a
// one-cycle command; entries shown on push_/wd retire at the same edge.
module stack_push_pack
    import stack_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_,
    input  logic [PUSH-1:0]      in_,
    input  logic [PUSH*DATA-1:0] in_d,
    output logic                 in_rdy,
    input  logic                 busy,
    output logic [PUSH-1:0]      push_,
    output logic [PUSH*DATA-1:0] wd,
    output logic [CNT_W-1:0]     cnt
`ifdef STACK_PUSH_PACK_STAT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    pp_state_e            state, state_nxt;
    ptr_t                 head, tail;
    stack_ent_t           fifo [BUF];
    logic [LANE_W-1:0]    acc_n, acc, iss_n;
    logic [PUSH*DATA-1:0] pk_d;

    lane_pack u_pack (
        .act    (~in_),
        .lane_d (in_d),
        .acc_n  (acc_n),
        .pk_d   (pk_d)
    );

    // Next state, acceptance and issue count.
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        acc       = '0;
        iss_n     = '0;
        case (state)
            PP_RUN:   if (!flush_) state_nxt = PP_FLUSH;
            PP_FLUSH: if (flush_)  state_nxt = PP_RUN;
            default:  state_nxt = PP_RUN;
        endcase
        in_rdy = (state == PP_RUN) && (cnt <= CNT_W'(BUF - PUSH));
        if (in_rdy && flush_) acc = acc_n;
        if (!busy && state == PP_RUN) begin
            if (cnt >= CNT_W'(PUSH)) iss_n = LANE_W'(PUSH);
            else                     iss_n = LANE_W'(cnt);
        end
    end

    // Issue mux: lanes below iss_n read the FIFO from head, others drive 0.
    always_comb begin
        push_ = '1;
        wd    = '0;
        for (int i = 0; i < PUSH; i++) begin
            if (LANE_W'(i) < iss_n) begin
                push_[i]          = 1'b0;
                wd[i*DATA +: DATA] = fifo[head + PTR_W'(i)];
            end
        end
    end

    // State, pointers and count; flush discards everything staged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PP_RUN;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (!flush_ || state == PP_FLUSH) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                head <= head + PTR_W'(iss_n);
                tail <= tail + PTR_W'(acc);
                cnt  <= cnt + CNT_W'(acc) - CNT_W'(iss_n);
            end
        end
    end

    // Staging storage; packed lanes append at tail in lane order.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH; k++) begin
            if (LANE_W'(k) < acc) begin
                fifo[tail + PTR_W'(k)] <= pk_d[k*DATA +: DATA];
            end
        end
    end

`ifdef STACK_PUSH_PACK_STAT_EN
    // Saturating count of cycles where producers or the stack are held off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!flush_) begin
            stall_cnt <= '0;
        end else if ((((|(~in_)) && !in_rdy) || (cnt != '0 && busy)) && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_push_pack.sv
// Bench for stack_push_pack: directed vector table, a mid-burst reset
// sequence, and a random phase checked against a count model and a
// queue of accepted entries in acceptance order.
module tb_stack_push_pack;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush_;
    logic [1:0]   in_;
    logic [127:0] in_d;
    logic         in_rdy;
    logic         busy;
    logic [1:0]   push_;
    logic [127:0] wd;
    logic [3:0]   cnt;
`ifdef STACK_PUSH_PACK_STAT_EN
    logic [31:0]  stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  in_n;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        busy;
        logic        fl_n;
        logic [1:0]  e_push;
        logic [63:0] e_wd0;
        logic [63:0] e_wd1;
        logic [3:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vt[$];

    stack_push_pack dut (
        .clk    (clk),
        .reset  (reset),
        .flush_ (flush_),
        .in_    (in_),
        .in_d   (in_d),
        .in_rdy (in_rdy),
        .busy   (busy),
        .push_  (push_),
        .wd     (wd),
        .cnt    (cnt)
`ifdef STACK_PUSH_PACK_STAT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] in_n, input logic [63:0] d0, input logic [63:0] d1,
                                input logic b, input logic fl_n, input logic [1:0] e_push,
                                input logic [63:0] e_wd0, input logic [63:0] e_wd1,
                                input logic [3:0] e_cnt, input logic e_rdy);
        vec_t v;
        v.in_n = in_n; v.d0 = d0; v.d1 = d1; v.busy = b; v.fl_n = fl_n;
        v.e_push = e_push; v.e_wd0 = e_wd0; v.e_wd1 = e_wd1; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
        return v;
    endfunction

    // Driver: apply one cycle of inputs just after the rising edge.
    task automatic drive(input logic [1:0] n, input logic [63:0] d0, input logic [63:0] d1,
                         input logic b, input logic fl_n);
        @(posedge clk);
        #1;
        in_    = n;
        in_d   = {d1, d0};
        busy   = b;
        flush_ = fl_n;
    endtask

    initial begin
        int m_cnt;
        int n_exp;
        logic [1:0] exp_push;
        logic exp_rdy;
        logic [1:0] rn;
        logic [63:0] r0, r1;
        logic rb;

        reset = 1'b1; flush_ = 1'b1; in_ = 2'b11; in_d = '0; busy = 1'b0;

        // Directed table: inputs for a cycle and the outputs expected in it.
        //            in_    d0     d1     busy fl  push   wd0    wd1    cnt rdy
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b11, 64'h0,  64'h0,  0, 1)); // reset state
        vt.push_back(mk(2'b01, 64'h0,  64'hA1, 0, 1, 2'b11, 64'h0,  64'h0,  0, 1)); // lane1 only
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b10, 64'hA1, 64'h0,  1, 1)); // packed to lane0
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b11, 64'h0,  64'h0,  0, 1));
        vt.push_back(mk(2'b00, 64'hA,  64'hB,  1, 1, 2'b11, 64'h0,  64'h0,  0, 1)); // fill while busy
        vt.push_back(mk(2'b00, 64'hC,  64'hD,  1, 1, 2'b11, 64'h0,  64'h0,  2, 1));
        vt.push_back(mk(2'b00, 64'hE,  64'hF,  1, 1, 2'b11, 64'h0,  64'h0,  4, 1));
        vt.push_back(mk(2'b00, 64'h10, 64'h11, 1, 1, 2'b11, 64'h0,  64'h0,  6, 1));
        vt.push_back(mk(2'b00, 64'h99, 64'h98, 1, 1, 2'b11, 64'h0,  64'h0,  8, 0)); // full: ignored
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b00, 64'hA,  64'hB,  8, 0)); // drain
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b00, 64'hC,  64'hD,  6, 1));
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b00, 64'hE,  64'hF,  4, 1));
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b00, 64'h10, 64'h11, 2, 1));
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b11, 64'h0,  64'h0,  0, 1)); // all high: no change
        vt.push_back(mk(2'b00, 64'h1,  64'h2,  1, 1, 2'b11, 64'h0,  64'h0,  0, 1)); // build cnt=7
        vt.push_back(mk(2'b00, 64'h3,  64'h4,  1, 1, 2'b11, 64'h0,  64'h0,  2, 1));
        vt.push_back(mk(2'b00, 64'h5,  64'h6,  1, 1, 2'b11, 64'h0,  64'h0,  4, 1));
        vt.push_back(mk(2'b10, 64'h7,  64'h0,  1, 1, 2'b11, 64'h0,  64'h0,  6, 1));
        vt.push_back(mk(2'b00, 64'h99, 64'h99, 1, 1, 2'b11, 64'h0,  64'h0,  7, 0)); // cnt=7: ignored
        vt.push_back(mk(2'b00, 64'h99, 64'h99, 1, 1, 2'b11, 64'h0,  64'h0,  7, 0));
        vt.push_back(mk(2'b00, 64'h99, 64'h99, 1, 0, 2'b11, 64'h0,  64'h0,  7, 0)); // flush + request
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b11, 64'h0,  64'h0,  0, 0)); // FLUSH state
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b11, 64'h0,  64'h0,  0, 1)); // back to RUN
        vt.push_back(mk(2'b10, 64'h33, 64'h0,  0, 1, 2'b11, 64'h0,  64'h0,  0, 1));
        vt.push_back(mk(2'b01, 64'h0,  64'h44, 0, 1, 2'b10, 64'h33, 64'h0,  1, 1)); // accept+issue
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b10, 64'h44, 64'h0,  1, 1));
        vt.push_back(mk(2'b11, 64'h0,  64'h0,  0, 1, 2'b11, 64'h0,  64'h0,  0, 1));

        // Reset block.
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].in_n, vt[i].d0, vt[i].d1, vt[i].busy, vt[i].fl_n);
            @(negedge clk);
            chk($sformatf("v%0d push_", i), 64'(push_), 64'(vt[i].e_push));
            chk($sformatf("v%0d wd0", i), wd[63:0], vt[i].e_wd0);
            chk($sformatf("v%0d wd1", i), wd[127:64], vt[i].e_wd1);
            chk($sformatf("v%0d cnt", i), 64'(cnt), 64'(vt[i].e_cnt));
            chk($sformatf("v%0d in_rdy", i), 64'(in_rdy), 64'(vt[i].e_rdy));
        end

        // Mid-burst reset: stage 6 entries while busy, then reset asynchronously.
        drive(2'b00, 64'h51, 64'h52, 1, 1);
        drive(2'b00, 64'h53, 64'h54, 1, 1);
        drive(2'b00, 64'h55, 64'h56, 1, 1);
        drive(2'b11, 64'h0, 64'h0, 1, 1);
        @(negedge clk);
        chk("pre_reset cnt", 64'(cnt), 64'd6);
        busy  = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_reset push_", 64'(push_), 64'(2'b11));
        chk("async_reset cnt", 64'(cnt), 64'd0);
        chk("async_reset in_rdy", 64'(in_rdy), 64'd1);
`ifdef STACK_PUSH_PACK_STAT_EN
        chk("async_reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;

        // Random phase: count model plus expected queue in acceptance order.
        m_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            rn = 2'($urandom_range(0, 3));
            r0 = {$urandom, $urandom};
            r1 = {$urandom, $urandom};
            rb = ($urandom_range(0, 2) == 0);
            drive(rn, r0, r1, rb, 1);
            @(negedge clk);
            exp_rdy = ((8 - m_cnt) >= 2);
            n_exp   = rb ? 0 : ((m_cnt < 2) ? m_cnt : 2);
            exp_push = (n_exp == 0) ? 2'b11 : ((n_exp == 1) ? 2'b10 : 2'b00);
            chk("rnd in_rdy", 64'(in_rdy), 64'(exp_rdy));
            chk("rnd push_", 64'(push_), 64'(exp_push));
            chk("rnd cnt", 64'(cnt), 64'(m_cnt));
            for (int i = 0; i < n_exp; i++) begin
                if (exp_q.size() > 0) begin
                    chk("rnd wd order", (i == 0) ? wd[63:0] : wd[127:64], exp_q.pop_front());
                end else begin
                    chk("rnd model underflow", 64'd1, 64'd0);
                end
            end
            m_cnt = m_cnt - n_exp;
            if (exp_rdy) begin
                if (!rn[0]) begin exp_q.push_back(r0); m_cnt++; end
                if (!rn[1]) begin exp_q.push_back(r1); m_cnt++; end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
